// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: memory op codes,
// FSM states, byte-enable patterns and op classification helpers.
package mem_lsu_pkg;

    typedef enum logic [3:0] {
        MEM_OP_NONE = 4'd0,
        MEM_OP_LB   = 4'd1,
        MEM_OP_LBU  = 4'd2,
        MEM_OP_LH   = 4'd3,
        MEM_OP_LHU  = 4'd4,
        MEM_OP_LW   = 4'd5,
        MEM_OP_SB   = 4'd6,
        MEM_OP_SH   = 4'd7,
        MEM_OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Encodings 9..15 are not memory ops and behave like NONE.
    function automatic logic is_mem(input logic [3:0] op);
        return (op >= MEM_OP_LB) && (op <= MEM_OP_SW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: byte enables, alignment check, store-lane
// replication and load lane selection with sign/zero extension.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic        misaligned,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane decode for the current op and low address bits.
    always_comb begin
        be          = BE_NONE;
        misaligned  = 1'b0;
        store_lanes = sdata;
        load_data   = rdata;
        byte_s      = rdata[{addr_lo, 3'b000} +: 8];
        half_s      = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: begin
                be         = BE_BYTE0 << addr_lo;
                misaligned = 1'b0;
            end
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: begin
                be         = addr_lo[1] ? BE_HI_HALF : BE_LO_HALF;
                misaligned = addr_lo[0];
            end
            MEM_OP_LW, MEM_OP_SW: begin
                be         = BE_WORD;
                misaligned = |addr_lo;
            end
            default: begin
                be         = BE_NONE;
                misaligned = 1'b0;
            end
        endcase

        case (op)
            MEM_OP_SB: store_lanes = {4{sdata[7:0]}};
            MEM_OP_SH: store_lanes = {2{sdata[15:0]}};
            default:   store_lanes = sdata;
        endcase

        case (op)
            MEM_OP_LB:  load_data = {{24{byte_s[7]}}, byte_s};
            MEM_OP_LBU: load_data = {24'd0, byte_s};
            MEM_OP_LH:  load_data = {{16{half_s[15]}}, half_s};
            MEM_OP_LHU: load_data = {16'd0, half_s};
            default:    load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage: issues one data-memory access per load/store over a req/ack
// port, stalls the pipeline meanwhile, and registers the MEM/WB results.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int REG_AW      = 5,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [3:0]        mem_op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       sdata_i,
    input  logic [31:0]       wdata_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic              we_i,
    output logic              stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic [31:0]       dmem_rdata_i,
    input  logic              dmem_ack_i,
    output logic [31:0]       wdata_o,
    output logic [REG_AW-1:0] waddr_o,
    output logic              we_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic              buserr_o,
    output logic [ADDR_W-1:0] badvaddr_o
);

    localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_e            state_r;
    logic [3:0]        op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [REG_AW-1:0] waddr_lat_r;
    logic              we_lat_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              dmem_req_r, dmem_we_r;
    logic [ADDR_W-1:0] dmem_addr_r;
    logic [3:0]        dmem_be_r;
    logic [31:0]       dmem_wdata_r;
    logic [31:0]       wdata_r;
    logic [REG_AW-1:0] waddr_r;
    logic              we_r, adel_r, ades_r, buserr_r;
    logic [ADDR_W-1:0] badvaddr_r;

    logic              in_req_s;
    logic [3:0]        sel_op_s;
    logic [1:0]        sel_lo_s;
    logic [3:0]        be_s;
    logic              misaligned_s;
    logic [31:0]       lanes_s, load_s;
    logic              accept_s, timeout_s, stall_s;

    // While waiting for ack the lane logic decodes the latched access so
    // the load extension uses the original op and address.
    assign in_req_s = (state_r == ST_REQ);
    assign sel_op_s = in_req_s ? op_r : mem_op_i;
    assign sel_lo_s = in_req_s ? addr_r[1:0] : addr_i[1:0];

    mem_lsu_align u_align (
        .op          (sel_op_s),
        .addr_lo     (sel_lo_s),
        .sdata       (sdata_i),
        .rdata       (dmem_rdata_i),
        .be          (be_s),
        .misaligned  (misaligned_s),
        .store_lanes (lanes_s),
        .load_data   (load_s)
    );

    assign accept_s  = !in_req_s && valid_i && is_mem(mem_op_i) && !misaligned_s;
    assign timeout_s = in_req_s && !dmem_ack_i && (cnt_r == CNT_LAST);

    // Stall is combinational so the earlier stages freeze in the same cycle.
    always_comb begin
        stall_s = 1'b0;
        if (in_req_s) begin
            stall_s = !dmem_ack_i && !timeout_s;
        end else begin
            stall_s = accept_s;
        end
    end

    // FSM, timeout counter, dmem port registers and MEM/WB registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            op_r         <= 4'd0;
            addr_r       <= '0;
            waddr_lat_r  <= '0;
            we_lat_r     <= 1'b0;
            cnt_r        <= '0;
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= '0;
            dmem_be_r    <= 4'd0;
            dmem_wdata_r <= 32'd0;
            wdata_r      <= 32'd0;
            waddr_r      <= '0;
            we_r         <= 1'b0;
            adel_r       <= 1'b0;
            ades_r       <= 1'b0;
            buserr_r     <= 1'b0;
            badvaddr_r   <= '0;
        end else begin
            we_r     <= 1'b0;
            adel_r   <= 1'b0;
            ades_r   <= 1'b0;
            buserr_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!valid_i) begin
                        we_r <= 1'b0;
                    end else if (!is_mem(mem_op_i)) begin
                        wdata_r <= wdata_i;
                        waddr_r <= waddr_i;
                        we_r    <= we_i;
                    end else if (misaligned_s) begin
                        adel_r     <= !is_store(mem_op_i);
                        ades_r     <= is_store(mem_op_i);
                        badvaddr_r <= addr_i;
                    end else begin
                        op_r         <= mem_op_i;
                        addr_r       <= addr_i;
                        waddr_lat_r  <= waddr_i;
                        we_lat_r     <= we_i;
                        cnt_r        <= '0;
                        dmem_req_r   <= 1'b1;
                        dmem_we_r    <= is_store(mem_op_i);
                        dmem_addr_r  <= {addr_i[ADDR_W-1:2], 2'b00};
                        dmem_be_r    <= be_s;
                        dmem_wdata_r <= lanes_s;
                        state_r      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dmem_ack_i) begin
                        dmem_req_r <= 1'b0;
                        state_r    <= ST_IDLE;
                        if (!is_store(op_r)) begin
                            wdata_r <= load_s;
                            waddr_r <= waddr_lat_r;
                            we_r    <= we_lat_r;
                        end else begin
                            we_r <= 1'b0;
                        end
                    end else if (cnt_r == CNT_LAST) begin
                        dmem_req_r <= 1'b0;
                        state_r    <= ST_IDLE;
                        buserr_r   <= 1'b1;
                        badvaddr_r <= addr_r;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    dmem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign stall_o      = stall_s;
    assign dmem_req_o   = dmem_req_r;
    assign dmem_we_o    = dmem_we_r;
    assign dmem_addr_o  = dmem_addr_r;
    assign dmem_be_o    = dmem_be_r;
    assign dmem_wdata_o = dmem_wdata_r;
    assign wdata_o      = wdata_r;
    assign waddr_o      = waddr_r;
    assign we_o         = we_r;
    assign adel_o       = adel_r;
    assign ades_o       = ades_r;
    assign buserr_o     = buserr_r;
    assign badvaddr_o   = badvaddr_r;

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Next-generation MEM stage for the Simple-MIPS pipeline, replacing the pure pass-through.
- Performs real data-memory access: LB/LBU/LH/LHU/LW/SB/SH/SW over a req/ack data-memory port, with byte enables and load extension.
- Stalls the pipeline while an access is outstanding, and flags misalignment and bus timeout.
- Drives registered MEM/WB outputs: wdata, waddr, we.

Parameters:
- ADDR_W, 32, data-memory byte-address width.
- REG_AW, 5, register-file address width.
- ACK_TIMEOUT, 16, cycles in REQ without ack before bus error (>=2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- valid_i  in  1  EX/MEM holds a valid instruction.
- mem_op_i  in  4  0=NONE,1=LB,2=LBU,3=LH,4=LHU,5=LW,6=SB,7=SH,8=SW; others treated as NONE.
- addr_i  in  ADDR_W  effective byte address.
- sdata_i  in  32  store data (rt).
- wdata_i  in  32  ALU result, used when op is NONE.
- waddr_i  in  REG_AW  destination register.
- we_i  in  1  register write enable.
- stall_o  out  1  hold EX/MEM and earlier stages.
- dmem_req_o  out  1  access request.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  ADDR_W  word-aligned address, low 2 bits always 0.
- dmem_be_o  out  4  byte-lane enables.
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_rdata_i  in  32  read data, valid with ack.
- dmem_ack_i  in  1  access complete.
- wdata_o  out  32  MEM/WB write data.
- waddr_o  out  REG_AW  MEM/WB write address.
- we_o  out  1  MEM/WB write enable.
- adel_o  out  1  one-cycle pulse: misaligned load.
- ades_o  out  1  one-cycle pulse: misaligned store.
- buserr_o  out  1  one-cycle pulse: ack timeout.
- badvaddr_o  out  ADDR_W  faulting address, held until the next fault.

Behaviour:
- Reset (rst=0, asynchronous): all outputs and registers 0; state=IDLE. An in-flight request is dropped immediately; a late ack after reset is ignored.
- FSM states: IDLE, REQ.
- IDLE, !valid_i: next cycle we_o=0 (bubble).
- IDLE, valid_i, op NONE: next cycle wdata_o/waddr_o/we_o = inputs; stall_o=0. Latency 1.
- IDLE, valid_i, mem op:
  - Alignment rule: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0.
  - Misaligned: no request; next cycle adel_o or ades_o=1, badvaddr_o=addr_i, we_o=0; stall_o=0.
  - Aligned: latch op/addr/sdata/waddr/we; register the dmem outputs; go to REQ; stall_o=1 this cycle.
- Byte enables:
  - Byte ops: be = 1<<addr[1:0].
  - Half ops: be = addr[1] ? 4'b1100 : 4'b0011.
  - Word ops: be = 4'b1111.
- Store data: SB replicates sdata[7:0] to all four lanes; SH replicates sdata[15:0] to both halves.
- REQ: dmem_req_o=1; address, be, wdata and we held stable until ack; stall_o = !dmem_ack_i.
- Ack in REQ: go to IDLE; next cycle MEM/WB is written.
  - Loads: selected lane is sign- (LB/LH) or zero-extended (LBU/LHU), LW taken whole; we_o=latched we.
  - Stores: we_o=0.
  - Minimum memory-op latency: 2 cycles (accept + ack).
- Timeout: cycle counter cleared on REQ entry. If it reaches ACK_TIMEOUT-1 without ack:
  - drop req, go to IDLE, stall_o=0;
  - next cycle buserr_o=1, badvaddr_o=latched addr, we_o=0.
  - Ack in that same cycle wins over timeout.
- Inputs are ignored while in REQ: the instruction stays presented because stall_o=1.
- waddr=0 is passed through; the register file discards it.
- Fault pulses are mutually exclusive and last exactly one cycle.

Decomposition:
- Package mem_lsu_pkg:
  - mem_op encodings (MEM_OP_NONE..MEM_OP_SW);
  - state encoding;
  - be constants.
- Sub-module mem_lsu_align (combinational):
  - inputs op, addr[1:0], sdata, rdata;
  - outputs be, misaligned, store lanes, extended load data.
- FSM, timeout counter and MEM/WB registers stay in mem_lsu.

Test Plan:
- Reset/pass-through: rst low for 3 cycles → all outputs 0. Release; ALU op wdata=0x1234_5678, waddr=3, we=1 → next cycle same on MEM/WB; stall_o never high.
- LB sign extension: addr=0x103, rdata=0x80FF_FF00, ack 1 cycle after req → be=4'b1000, dmem_addr=0x100, stall 2 cycles, wdata_o=0xFFFF_FF80. Repeat with LBU → 0x0000_0080.
- SH lanes: addr=0x202, sdata=0xAAAA_BEEF → be=4'b1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1; after ack, we_o=0.
- Misaligned LW at 0x301 → no dmem_req, adel_o pulse, badvaddr_o=0x301, we_o=0. SW at 0x302 → ades_o pulse.
- Timeout: ACK_TIMEOUT=4, ack never asserted → req high 4 cycles then drops, buserr_o pulse, stall released. Ack on the final cycle instead → normal load completion, no buserr_o.
- Reset mid-REQ: assert rst while dmem_req_o=1 → req drops asynchronously, state IDLE; a later ack produces no write.
